mcp3008_spi_reader: RTL



---
 rtl/mcp3008_spi_reader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mcp3008_spi_reader.sv
// SPI master running single MCP3008 10-bit conversions (mode 0,0), one per accepted start.
// Optional ADC_AVG4_EN: output is the running average of the last four results on a channel.
module mcp3008_spi_reader #(
  parameter int CLK_DIV        = 14,
  parameter int CS_HIGH_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] ch_sel,
  input  logic       single_ended,
  output logic       ad_clk,
  output logic       cs,
  output logic       din,
  input  logic       dout,
  output logic [9:0] sample,
  output logic [2:0] sample_ch,
  output logic       sample_valid,
  output logic       busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CYCLES) ? CLK_DIV : CS_HIGH_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic          cs_q, cs_d, ad_clk_q, ad_clk_d, din_q, din_d;
  logic          busy_q, busy_d, valid_q, valid_d;
  logic [9:0]    shift_q, shift_d, sample_q, sample_d;
  logic [2:0]    sample_ch_q, sample_ch_d, ch_q, ch_d;
  logic          se_q, se_d;
  logic [1:0]    sync_q;
  logic          dout_sync, half_done, cmd_bit, hold_exit;
  logic [9:0]    result;

  assign dout_sync = sync_q[1];
  assign half_done = (cnt_q == DIV_LAST);
  assign hold_exit = (state_q == HOLD) && half_done;

  // Command bits after the start bit: SGL, D2, D1, D0, then zeros.
  always_comb begin
    cmd_bit = 1'b0;
    case (bit_q)
      5'd0:    cmd_bit = se_q;
      5'd1:    cmd_bit = ch_q[2];
      5'd2:    cmd_bit = ch_q[1];
      5'd3:    cmd_bit = ch_q[0];
      default: cmd_bit = 1'b0;
    endcase
  end

`ifdef ADC_AVG4_EN
  logic [9:0]  hist_q [4];
  logic [3:0]  prev_tag_q;
  logic        prev_vld_q;
  logic        new_chan;
  logic [11:0] sum;

  assign new_chan = !prev_vld_q || (prev_tag_q != {se_q, ch_q});
  assign sum      = 12'(shift_q) + 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]);
  assign result   = new_chan ? shift_q : sum[11:2];

  // A channel/mode change refills the whole history so stale data never mixes in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      prev_tag_q <= '0;
      prev_vld_q <= 1'b0;
    end else if (hold_exit) begin
      prev_tag_q <= {se_q, ch_q};
      prev_vld_q <= 1'b1;
      if (new_chan) begin
        for (int i = 0; i < 4; i++) hist_q[i] <= shift_q;
      end else begin
        hist_q[0] <= shift_q;
        hist_q[1] <= hist_q[0];
        hist_q[2] <= hist_q[1];
        hist_q[3] <= hist_q[2];
      end
    end
  end
`else
  assign result = shift_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    cs_d        = cs_q;
    ad_clk_d    = ad_clk_q;
    din_d       = din_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    shift_d     = shift_q;
    ch_d        = ch_q;
    se_d        = se_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          ch_d    = ch_sel;
          se_d    = single_ended;
          din_d   = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (half_done) begin
          cnt_d    = '0;
          ad_clk_d = 1'b1;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (half_done) begin
          cnt_d    = '0;
          ad_clk_d = ~ad_clk_q;
          // All bus activity happens on the falling SCLK edge; bit_q holds the finished period index.
          if (ad_clk_q) begin
            din_d = cmd_bit;
            if (bit_q >= 5'd7) shift_d = {shift_q[8:0], dout_sync};
            if (bit_q == 5'd16) begin
              bit_d   = '0;
              state_d = HOLD;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (half_done) begin
          cnt_d       = '0;
          cs_d        = 1'b1;
          valid_d     = 1'b1;
          sample_d    = result;
          sample_ch_d = ch_q;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      cs_q        <= 1'b1;
      ad_clk_q    <= 1'b0;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      shift_q     <= '0;
      ch_q        <= '0;
      se_q        <= 1'b0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      cs_q        <= cs_d;
      ad_clk_q    <= ad_clk_d;
      din_q       <= din_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      shift_q     <= shift_d;
      ch_q        <= ch_d;
      se_q        <= se_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      sync_q      <= {sync_q[0], dout};
    end
  end

  assign ad_clk       = ad_clk_q;
  assign cs           = cs_q;
  assign din          = din_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;

endmodule
